// File: rtl/rob_multi_wb.sv
// Reorder buffer with NWB writeback channels, in-order single-entry commit,
// mispredict flush with redirect PC, store-commit release and bypassed operand lookup.
module rob_multi_wb #(
  parameter int ROB_BITS = 4,
  parameter int NWB      = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    is_ins,
  input  logic [31:0]             ins_pc,
  input  logic [1:0]              ins_type,
  input  logic [4:0]              ins_rd,
  input  logic                    ins_pred_jmp,
  input  logic                    ins_already_done,
  input  logic [31:0]             ins_val,
  output logic                    rob_full,
  output logic                    rob_empty,
  output logic [ROB_BITS-1:0]     rob_free_id,
  output logic [4:0]              set_dep_id,
  output logic [ROB_BITS-1:0]     set_dep_Q,
  input  logic [NWB-1:0]          wb_valid,
  input  logic [NWB*ROB_BITS-1:0] wb_rob_id,
  input  logic [NWB*32-1:0]       wb_val,
  input  logic [NWB-1:0]          wb_jmp,
  input  logic [NWB*32-1:0]       wb_new_pc,
  output logic [ROB_BITS-1:0]     rob_head_id,
  output logic                    commit_valid,
  output logic [4:0]              commit_rd,
  output logic [31:0]             commit_val,
  output logic [ROB_BITS-1:0]     commit_rob_id,
  output logic                    store_commit,
  output logic                    rob_clear,
  output logic [31:0]             clear_pc,
  input  logic [ROB_BITS-1:0]     get_rob_id_1,
  input  logic [ROB_BITS-1:0]     get_rob_id_2,
  output logic                    rob_avail_1,
  output logic [31:0]             rob_val_1,
  output logic                    rob_avail_2,
  output logic [31:0]             rob_val_2
);
  localparam int DEPTH = 1 << ROB_BITS;
  localparam logic [1:0] T_BR   = 2'd1;
  localparam logic [1:0] T_ST   = 2'd2;
  localparam logic [1:0] T_JALR = 2'd3;

  logic [ROB_BITS-1:0] head_q, head_d, tail_q, tail_d;
  logic [ROB_BITS:0]   count_q, count_d;
  logic [DEPTH-1:0]    busy_q, busy_d, ok_q, ok_d, pred_q, pred_d, jmp_q, jmp_d;
  logic [1:0]          type_q [DEPTH];
  logic [1:0]          type_d [DEPTH];
  logic [4:0]          rd_q [DEPTH];
  logic [4:0]          rd_d [DEPTH];
  logic [31:0]         val_q [DEPTH];
  logic [31:0]         val_d [DEPTH];
  logic [31:0]         npc_q [DEPTH];
  logic [31:0]         npc_d [DEPTH];

  logic                commit_valid_q, commit_valid_d, store_commit_q, store_commit_d;
  logic                rob_clear_q, rob_clear_d;
  logic [4:0]          commit_rd_q, commit_rd_d;
  logic [31:0]         commit_val_q, commit_val_d, clear_pc_q, clear_pc_d;
  logic [ROB_BITS-1:0] commit_rob_id_q, commit_rob_id_d;

  logic                issue_fire, commit_fire, mispredict;
  logic [1:0]          head_type;

  // Issue handshake: an issue is taken when is_ins is high, rob_full is low and
  // rob_clear is low; otherwise it is dropped and the decoder must retry.
  assign rob_empty   = (count_q == '0);
  assign rob_full    = (count_q >= (ROB_BITS+1)'(DEPTH-1));
  assign rob_free_id = tail_q;
  assign rob_head_id = head_q;
  assign set_dep_id  = (is_ins && ins_rd != 5'd0) ? ins_rd : 5'd0;
  assign set_dep_Q   = (is_ins && ins_rd != 5'd0) ? tail_q : '0;

  assign commit_valid  = commit_valid_q;
  assign commit_rd     = commit_rd_q;
  assign commit_val    = commit_val_q;
  assign commit_rob_id = commit_rob_id_q;
  assign store_commit  = store_commit_q;
  assign rob_clear     = rob_clear_q;
  assign clear_pc      = clear_pc_q;

  always_comb begin
    head_type   = type_q[head_q];
    commit_fire = busy_q[head_q] && ok_q[head_q];
    mispredict  = commit_fire && (head_type == T_JALR ||
                  (head_type == T_BR && jmp_q[head_q] != pred_q[head_q]));
    issue_fire  = is_ins && !rob_full && !rob_clear_q;

    head_d = head_q;  tail_d = tail_q;
    busy_d = busy_q;  ok_d = ok_q;  pred_d = pred_q;  jmp_d = jmp_q;
    type_d = type_q;  rd_d = rd_q;  val_d = val_q;    npc_d = npc_q;

    // Ascending channel order lets the highest index win a shared target.
    for (int w = 0; w < NWB; w++) begin
      if (wb_valid[w] && busy_q[wb_rob_id[w*ROB_BITS +: ROB_BITS]]) begin
        ok_d[wb_rob_id[w*ROB_BITS +: ROB_BITS]]  = 1'b1;
        val_d[wb_rob_id[w*ROB_BITS +: ROB_BITS]] = wb_val[w*32 +: 32];
        jmp_d[wb_rob_id[w*ROB_BITS +: ROB_BITS]] = wb_jmp[w];
        npc_d[wb_rob_id[w*ROB_BITS +: ROB_BITS]] = wb_new_pc[w*32 +: 32];
      end
    end

    if (commit_fire) begin
      busy_d[head_q] = 1'b0;
      head_d         = head_q + 1'b1;
    end

    if (issue_fire) begin
      busy_d[tail_q] = 1'b1;
      ok_d[tail_q]   = ins_already_done;
      val_d[tail_q]  = ins_val;
      type_d[tail_q] = ins_type;
      rd_d[tail_q]   = ins_rd;
      pred_d[tail_q] = ins_pred_jmp;
      tail_d         = tail_q + 1'b1;
    end

    count_d = count_q + (ROB_BITS+1)'(issue_fire) - (ROB_BITS+1)'(commit_fire);

    commit_valid_d  = commit_fire;
    store_commit_d  = commit_fire && head_type == T_ST;
    rob_clear_d     = mispredict;
    commit_rd_d     = commit_rd_q;
    commit_val_d    = commit_val_q;
    commit_rob_id_d = commit_rob_id_q;
    clear_pc_d      = clear_pc_q;
    if (commit_fire) begin
      commit_rd_d     = (head_type == T_BR || head_type == T_ST) ? 5'd0 : rd_q[head_q];
      commit_val_d    = val_q[head_q];
      commit_rob_id_d = head_q;
    end

    // Flush wins over the same-edge issue and writeback: everything younger is gone.
    if (mispredict) begin
      clear_pc_d = npc_q[head_q];
      busy_d     = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      busy_q          <= '0;
      ok_q            <= '0;
      commit_valid_q  <= 1'b0;
      store_commit_q  <= 1'b0;
      rob_clear_q     <= 1'b0;
      commit_rd_q     <= '0;
      commit_val_q    <= '0;
      commit_rob_id_q <= '0;
      clear_pc_q      <= '0;
    end else if (rdy_in) begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      busy_q          <= busy_d;
      ok_q            <= ok_d;
      pred_q          <= pred_d;
      jmp_q           <= jmp_d;
      type_q          <= type_d;
      rd_q            <= rd_d;
      val_q           <= val_d;
      npc_q           <= npc_d;
      commit_valid_q  <= commit_valid_d;
      store_commit_q  <= store_commit_d;
      rob_clear_q     <= rob_clear_d;
      commit_rd_q     <= commit_rd_d;
      commit_val_q    <= commit_val_d;
      commit_rob_id_q <= commit_rob_id_d;
      clear_pc_q      <= clear_pc_d;
    end
  end

  logic [ROB_BITS-1:0] lk_id [2];
  logic [1:0]          lk_avail;
  logic [31:0]         lk_val [2];

  always_comb begin
    lk_id[0] = get_rob_id_1;
    lk_id[1] = get_rob_id_2;
    for (int p = 0; p < 2; p++) begin
      lk_avail[p] = 1'b0;
      lk_val[p]   = '0;
      if (ok_q[lk_id[p]]) begin
        lk_avail[p] = 1'b1;
        lk_val[p]   = val_q[lk_id[p]];
      end else begin
        for (int w = 0; w < NWB; w++) begin
          if (wb_valid[w] && wb_rob_id[w*ROB_BITS +: ROB_BITS] == lk_id[p]) begin
            lk_avail[p] = 1'b1;
            lk_val[p]   = wb_val[w*32 +: 32];
          end
        end
      end
    end
  end

  assign rob_avail_1 = lk_avail[0];
  assign rob_val_1   = lk_val[0];
  assign rob_avail_2 = lk_avail[1];
  assign rob_val_2   = lk_val[1];

  // The issue PC is carried on the interface for the decoder's benefit only.
  logic unused_pc;
  assign unused_pc = ^ins_pc;
endmodule
